// File: rtl/psum_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_writeback_pkg
// Purpose  : Shared definitions for the partial-sum writeback block. Holds the
//            FSM state encoding and the default datapath widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package psum_writeback_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int PSUM_W_DEF = 19;
  localparam int ACC_W_DEF  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : psum_writeback_pkg
`default_nettype wire

// File: rtl/psum_writeback_quant.sv
`default_nettype none
// ============================================================================
// Module   : psum_quant
// Purpose  : Combinational requantisation of an accumulated sum to an 8-bit
//            signed pixel: arithmetic shift right, optional ReLU, saturation.
// Ports    : acc   - signed accumulated sum (ACC_W)
//            shift - arithmetic right-shift amount (4)
//            relu  - clamp negatives to zero before saturation
//            data  - signed 8-bit result
//            sat   - result was clipped to [-128,127]
// Revision : 1.0 - initial release
// ============================================================================
module psum_quant
  import psum_writeback_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [3:0]       shift,
  input  logic                    relu,
  output logic signed [7:0]       data,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] C_MIN = -ACC_W'(128);

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] rectified;

  always_comb begin
    // >>> on a signed operand floors toward -inf.
    shifted   = acc >>> shift;
    rectified = shifted;
    if (relu && shifted[ACC_W-1]) begin
      rectified = '0;
    end
    data = rectified[7:0];
    sat  = 1'b0;
    if (rectified > C_MAX) begin
      data = 8'sd127;
      sat  = 1'b1;
    end else if (rectified < C_MIN) begin
      data = -8'sd128;
      sat  = 1'b1;
    end
  end

endmodule : psum_quant
`default_nettype wire

// File: rtl/psum_writeback.sv
`default_nettype none
// ============================================================================
// Module   : psum_writeback
// Purpose  : Accumulates cfg_passes partial sums per output pixel, requantises
//            each finished pixel and writes it to the ofmap buffer. A job is
//            launched by a start pulse and ends with a one-cycle done pulse.
// Ports    : clk, rst (async, active-low)
//            start, cfg_passes, cfg_npix, cfg_shift, cfg_relu - job config
//            psum_in, psum_valid                             - PE group sums
//            ofmap_we, ofmap_addr, ofmap_data                - buffer write
//            busy, done, sat_flag                            - status
// Revision : 1.0 - initial release
// ============================================================================
module psum_writeback
  import psum_writeback_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic        [3:0]        cfg_passes,
  input  logic        [ADDR_W-1:0] cfg_npix,
  input  logic        [3:0]        cfg_shift,
  input  logic                     cfg_relu,
  input  logic signed [PSUM_W-1:0] psum_in,
  input  logic                     psum_valid,
  output logic                     ofmap_we,
  output logic        [ADDR_W-1:0] ofmap_addr,
  output logic signed [7:0]        ofmap_data,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag
);

  state_t state, next_state;

  logic        [3:0]        passes_m1;
  logic        [ADDR_W-1:0] npix_q;
  logic        [3:0]        shift_q;
  logic                     relu_q;
  logic        [3:0]        pass_cnt;
  logic        [ADDR_W-1:0] in_cnt;   // pixels fully accumulated
  logic        [ADDR_W-1:0] pix_cnt;  // pixels written
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  total;
  logic                     wr_pend;

  logic signed [ACC_W-1:0]  psum_ext;
  logic signed [ACC_W-1:0]  sum;
  logic        [ADDR_W-1:0] last_pix_idx;
  logic                     beat;
  logic                     last_pass;
  logic                     last_pix;
  logic signed [7:0]        q_data;
  logic                     q_sat;

  assign psum_ext     = {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
  assign sum          = acc + psum_ext;
  assign last_pix_idx = npix_q - 1'b1;
  assign beat         = (state == ST_ACCUM) && psum_valid;
  assign last_pass    = (pass_cnt == passes_m1);
  assign last_pix     = (in_cnt == last_pix_idx);

  psum_quant #(
    .ACC_W (ACC_W)
  ) u_quant (
    .acc   (total),
    .shift (shift_q),
    .relu  (relu_q),
    .data  (q_data),
    .sat   (q_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (cfg_npix == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat && last_pass && last_pix) begin
          next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Leave only once the final strobe has been driven and retired so
        // done lands two cycles after the last write.
        if (!wr_pend && !ofmap_we) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      passes_m1  <= '0;
      npix_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      pass_cnt   <= '0;
      in_cnt     <= '0;
      pix_cnt    <= '0;
      acc        <= '0;
      total      <= '0;
      wr_pend    <= 1'b0;
      ofmap_we   <= 1'b0;
      ofmap_addr <= '0;
      ofmap_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      ofmap_we <= 1'b0;
      busy     <= (next_state != ST_IDLE);
      done     <= (next_state == ST_DONE);

      if (state == ST_IDLE && start) begin
        passes_m1 <= (cfg_passes == 4'd0) ? 4'd0 : (cfg_passes - 4'd1);
        npix_q    <= cfg_npix;
        shift_q   <= cfg_shift;
        relu_q    <= cfg_relu;
        pass_cnt  <= '0;
        in_cnt    <= '0;
        pix_cnt   <= '0;
        acc       <= '0;
        wr_pend   <= 1'b0;
        sat_flag  <= 1'b0;
      end

      // Write stage: retires the previously completed pixel.
      if (wr_pend) begin
        ofmap_we   <= 1'b1;
        ofmap_addr <= pix_cnt;
        ofmap_data <= q_data;
        pix_cnt    <= pix_cnt + 1'b1;
        wr_pend    <= 1'b0;
        if (q_sat) begin
          sat_flag <= 1'b1;
        end
      end

      // Accumulate stage; a pixel completing here re-arms wr_pend, which
      // overrides the clear above so back-to-back pixels never stall.
      if (beat) begin
        if (!last_pass) begin
          acc      <= sum;
          pass_cnt <= pass_cnt + 4'd1;
        end else begin
          total    <= sum;
          acc      <= '0;
          pass_cnt <= '0;
          in_cnt   <= in_cnt + 1'b1;
          wr_pend  <= 1'b1;
        end
      end
    end
  end

endmodule : psum_writeback
`default_nettype wire

// File: tb/tb_psum_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_writeback
// Purpose  : Directed self-checking bench for psum_writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_writeback;

  localparam int ADDR_W = 10;
  localparam int PSUM_W = 19;
  localparam int ACC_W  = 24;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start = 1'b0;
  logic        [3:0]        cfg_passes = '0;
  logic        [ADDR_W-1:0] cfg_npix = '0;
  logic        [3:0]        cfg_shift = '0;
  logic                     cfg_relu = 1'b0;
  logic signed [PSUM_W-1:0] psum_in = '0;
  logic                     psum_valid = 1'b0;
  logic                     ofmap_we;
  logic        [ADDR_W-1:0] ofmap_addr;
  logic signed [7:0]        ofmap_data;
  logic                     busy;
  logic                     done;
  logic                     sat_flag;

  psum_writeback #(
    .ADDR_W (ADDR_W),
    .PSUM_W (PSUM_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_passes (cfg_passes),
    .cfg_npix   (cfg_npix),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .psum_in    (psum_in),
    .psum_valid (psum_valid),
    .ofmap_we   (ofmap_we),
    .ofmap_addr (ofmap_addr),
    .ofmap_data (ofmap_data),
    .busy       (busy),
    .done       (done),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_a[$];
  int wr_d[$];
  int wr_c[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int beat_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ofmap_we) begin
      wr_a.push_back(int'(ofmap_addr));
      wr_d.push_back(int'(ofmap_data));
      wr_c.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    wr_c.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input int p, input int n, input int s, input int r);
    @(negedge clk);
    cfg_passes = 4'(p);
    cfg_npix   = ADDR_W'(n);
    cfg_shift  = 4'(s);
    cfg_relu   = r[0];
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Present one valid beat for a single cycle; call at a negedge.
  task automatic beat(input int v);
    psum_valid = 1'b1;
    psum_in    = PSUM_W'(v);
    beat_cyc   = cyc;
    @(negedge clk);
    psum_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != 0) break;
    end
    repeat (4) @(negedge clk);
    check({tag, "_done"}, done_cnt, 1);
  endtask

  task automatic check_wr(input string tag, input int i, input int a, input int d);
    if (wr_a.size() > i) begin
      check({tag, "_addr"}, wr_a[i], a);
      check({tag, "_data"}, wr_d[i], d);
    end else begin
      check({tag, "_present"}, wr_a.size(), i + 1);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_we",   int'(ofmap_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sat",  int'(sat_flag), 0);
    check("rst_addr", int'(ofmap_addr), 0);
    check("rst_data", int'(ofmap_data), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single-pass, back-to-back pixels
    clear_log();
    do_start(1, 3, 0, 0);
    check("t1_busy", int'(busy), 1);
    beat(5);
    beat(-7);
    beat(127);
    wait_done("t1", 40);
    check("t1_nwr", wr_a.size(), 3);
    check_wr("t1_w0", 0, 0, 5);
    check_wr("t1_w1", 1, 1, -7);
    check_wr("t1_w2", 2, 2, 127);
    if (wr_c.size() == 3) begin
      check("t1_latency", wr_c[2] - beat_cyc, 2);
      check("t1_done_gap", done_cyc - wr_c[2], 2);
    end
    check("t1_sat", int'(sat_flag), 0);
    check("t1_idle", int'(busy), 0);

    // Four passes with gaps and shift
    clear_log();
    do_start(4, 1, 2, 0);
    beat(100); repeat (2) @(negedge clk);
    beat(200); repeat (2) @(negedge clk);
    beat(-50); repeat (2) @(negedge clk);
    beat(10);
    wait_done("t2", 40);
    check("t2_nwr", wr_a.size(), 1);
    check_wr("t2_w0", 0, 0, 65);

    // ReLU and positive saturation
    clear_log();
    do_start(2, 2, 0, 1);
    beat(-300);
    beat(100);
    beat(200);
    beat(100);
    wait_done("t3", 40);
    check("t3_nwr", wr_a.size(), 2);
    check_wr("t3_w0", 0, 0, 0);
    check_wr("t3_w1", 1, 1, 127);
    check("t3_sat", int'(sat_flag), 1);

    // Empty job; sat_flag cleared by start; psum_valid in IDLE ignored
    clear_log();
    do_start(1, 0, 0, 0);
    check("t4_sat_clr", int'(sat_flag), 0);
    wait_done("t4", 20);
    beat(33);
    beat(44);
    repeat (5) @(negedge clk);
    check("t4_nwr", wr_a.size(), 0);
    check("t4_busy", int'(busy), 0);

    // Reset mid-pixel, then recover
    clear_log();
    do_start(4, 2, 0, 0);
    beat(1);
    beat(2);
    rst = 1'b0;
    #1;
    check("t5_busy_rst", int'(busy), 0);
    check("t5_we_rst", int'(ofmap_we), 0);
    repeat (5) @(negedge clk);
    check("t5_nwr_rst", wr_a.size(), 0);
    check("t5_done_rst", done_cnt, 0);
    rst = 1'b1;
    @(negedge clk);
    do_start(1, 1, 0, 0);
    beat(9);
    wait_done("t5", 40);
    check("t5_nwr", wr_a.size(), 1);
    check_wr("t5_w0", 0, 0, 9);

    // start while busy is ignored
    clear_log();
    do_start(1, 3, 0, 0);
    beat(1);
    cfg_passes = 4'd4;
    cfg_npix   = ADDR_W'(1);
    cfg_shift  = 4'd3;
    start      = 1'b1;
    beat(2);
    start      = 1'b0;
    beat(3);
    wait_done("t6", 40);
    check("t6_nwr", wr_a.size(), 3);
    check_wr("t6_w0", 0, 0, 1);
    check_wr("t6_w1", 1, 1, 2);
    check_wr("t6_w2", 2, 2, 3);

    // passes=0 acts as 1; floor shift; negative saturation
    clear_log();
    do_start(0, 2, 1, 0);
    beat(-3);
    beat(-1000);
    wait_done("t7", 40);
    check("t7_nwr", wr_a.size(), 2);
    check_wr("t7_w0", 0, 0, -2);
    check_wr("t7_w1", 1, 1, -128);
    check("t7_sat", int'(sat_flag), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_psum_writeback
`default_nettype wire
